// File: rtl/spi_dev_cmdq.sv
// spi_dev_cmdq: decodes a range of SPI command bytes, packs payloads into words, and queues them in one shared FWFT queue.
// Optional macro SPI_DEV_CMDQ_IRQ_EN enables the low-watermark irq; without it irq is held low.
module spi_dev_cmdq #(
  parameter int         N_CH     = 2,
  parameter logic [7:0] CMD_BASE = 8'he2,
  parameter int         CMD_LEN  = 8,
  parameter int         DEPTH    = 256,
  parameter int         LOW_WM   = 16,
  localparam int        W        = 8 * CMD_LEN,
  localparam int        LW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    pw_wdata,
  input  logic          pw_wcmd,
  input  logic          pw_wstb,
  input  logic          pw_end,
  output logic [W-1:0]  out_data,
  output logic [1:0]    out_chan,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [LW-1:0] level,
  output logic [7:0]    drop_cnt,
  input  logic          ovf_clr,
  output logic          irq
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [8:0] CMD_END = {1'b0, CMD_BASE} + 9'(N_CH);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t       state, state_n;
  logic [1:0]   chan, chan_n;
  logic [4:0]   cnt, cnt_n;
  logic [W-1:0] asm_word, asm_n;
  logic         push_pend, push_pend_n;
  logic [W+1:0] push_ent, push_ent_n;

  logic         cmd_hit;
  logic [1:0]   cmd_chan;
  logic         data_stb;
  logic [W-1:0] asm_shift;

  // Only the low two bits of the channel offset matter since N_CH <= 4.
  assign cmd_hit   = pw_wstb & pw_wcmd &
                     ({1'b0, pw_wdata} >= {1'b0, CMD_BASE}) &
                     ({1'b0, pw_wdata} < CMD_END);
  assign cmd_chan  = pw_wdata[1:0] - CMD_BASE[1:0];
  assign data_stb  = pw_wstb & ~pw_wcmd;
  assign asm_shift = (asm_word << 8) | W'(pw_wdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      chan      <= '0;
      cnt       <= '0;
      asm_word  <= '0;
      push_pend <= 1'b0;
      push_ent  <= '0;
    end else begin
      state     <= state_n;
      chan      <= chan_n;
      cnt       <= cnt_n;
      asm_word  <= asm_n;
      push_pend <= push_pend_n;
      push_ent  <= push_ent_n;
    end
  end

  // A completing byte is captured before pw_end or a new command can discard the partial word.
  always_comb begin
    state_n     = state;
    chan_n      = chan;
    cnt_n       = cnt;
    asm_n       = asm_word;
    push_pend_n = 1'b0;
    push_ent_n  = push_ent;
    if (state == COLLECT && data_stb) begin
      asm_n = asm_shift;
      cnt_n = cnt + 5'd1;
      if (cnt_n == 5'(CMD_LEN)) begin
        push_pend_n = 1'b1;
        push_ent_n  = {chan, asm_shift};
        cnt_n       = '0;
      end
    end
    if (pw_end) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (pw_wstb & pw_wcmd) begin
      cnt_n = '0;
      if (cmd_hit) begin
        state_n = COLLECT;
        chan_n  = cmd_chan;
      end else begin
        state_n = IDLE;
      end
    end
  end

  logic [W+1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop, wr_en, load;
  logic [LW-1:0] ram_cnt;

  // The head word lives in the output register, so the RAM holds level minus that one entry.
  assign pop     = out_valid & out_ready;
  assign wr_en   = push_pend & ((level < LW'(DEPTH)) | pop);
  assign ram_cnt = level - LW'(out_valid);
  assign load    = (ram_cnt != '0) & (~out_valid | pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_ent;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (load) begin
        rd_ptr                <= rd_ptr + AW'(1);
        {out_chan, out_data}  <= mem[rd_ptr];
        out_valid             <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
      level <= level + LW'(wr_en) - LW'(pop);
    end
  end

  // Clear has priority over a drop landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || ovf_clr) begin
      drop_cnt <= '0;
    end else if (push_pend && !wr_en && drop_cnt != 8'hff) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

`ifdef SPI_DEV_CMDQ_IRQ_EN
  logic pushed_ever;

  always_ff @(posedge clk) begin
    if (rst) begin
      pushed_ever <= 1'b0;
      irq         <= 1'b0;
    end else begin
      if (wr_en) pushed_ever <= 1'b1;
      irq <= pushed_ever & (level <= LW'(LOW_WM));
    end
  end
`else
  // Feature off: a legal (non-negative) watermark makes this constant low.
  assign irq = (LOW_WM < 0);
`endif

endmodule

// File: tb/tb_spi_dev_cmdq.sv
// tb_spi_dev_cmdq: directed stimulus against a queue-level behavioural model, checked every cycle.
// Honours SPI_DEV_CMDQ_IRQ_EN when deciding what irq must do.
module tb_spi_dev_cmdq;

  localparam int         N_CH     = 2;
  localparam logic [7:0] CMD_BASE = 8'he2;
  localparam int         CMD_LEN  = 8;
  localparam int         DEPTH    = 4;
  localparam int         LOW_WM   = 1;
  localparam int         W        = 64;
`ifdef SPI_DEV_CMDQ_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   pw_wdata = '0;
  logic         pw_wcmd = 1'b0;
  logic         pw_wstb = 1'b0;
  logic         pw_end = 1'b0;
  logic [W-1:0] out_data;
  logic [1:0]   out_chan;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [2:0]   level;
  logic [7:0]   drop_cnt;
  logic         ovf_clr = 1'b0;
  logic         irq;

  int total = 0;
  int bad = 0;

  spi_dev_cmdq #(
    .N_CH(N_CH), .CMD_BASE(CMD_BASE), .CMD_LEN(CMD_LEN), .DEPTH(DEPTH), .LOW_WM(LOW_WM)
  ) dut (
    .clk(clk), .rst(rst),
    .pw_wdata(pw_wdata), .pw_wcmd(pw_wcmd), .pw_wstb(pw_wstb), .pw_end(pw_end),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .drop_cnt(drop_cnt), .ovf_clr(ovf_clr), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: words are a FIFO of entries stamped with their write edge; head shows one edge after write.
  typedef struct {
    logic [63:0] word;
    logic [1:0]  chan;
    int          wr_edge;
  } entry_t;

  entry_t      mq[$];
  logic [7:0]  m_buf[$];
  bit          model_live = 0;
  bit          m_vis, m_irq, m_ever, m_pend, m_coll;
  int          m_drop;
  logic [63:0] m_pword;
  logic [1:0]  m_pchan, m_chan;
  int          cyc = 0;

  initial begin
    int     lvl;
    bit     pop, is_match;
    entry_t e;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        mq.delete(); m_buf.delete();
        m_vis = 0; m_irq = 0; m_ever = 0; m_pend = 0; m_coll = 0;
        m_drop = 0; m_chan = 0;
        model_live = 1;
      end else begin
        lvl = mq.size();
        pop = m_vis && out_ready;
        m_irq = IRQ_ON && m_ever && (lvl <= LOW_WM);
        if (pop) begin
          void'(mq.pop_front());
          m_vis = 0;
        end
        if (m_pend) begin
          if (lvl < DEPTH || pop) begin
            e.word = m_pword; e.chan = m_pchan; e.wr_edge = cyc;
            mq.push_back(e);
            m_ever = 1;
          end else if (m_drop < 255) begin
            m_drop++;
          end
          m_pend = 0;
        end
        if (ovf_clr) m_drop = 0;
        if (!m_vis && mq.size() > 0 && mq[0].wr_edge < cyc) m_vis = 1;
        is_match = (int'(pw_wdata) >= int'(CMD_BASE)) && (int'(pw_wdata) < int'(CMD_BASE) + N_CH);
        if (pw_wstb && !pw_wcmd && m_coll) begin
          m_buf.push_back(pw_wdata);
          if (m_buf.size() == CMD_LEN) begin
            m_pword = 0;
            foreach (m_buf[i]) m_pword = m_pword * 256 + 64'(m_buf[i]);
            m_pchan = m_chan;
            m_pend = 1;
            m_buf.delete();
          end
        end
        if (pw_end) begin
          m_coll = 0;
          m_buf.delete();
        end else if (pw_wstb && pw_wcmd) begin
          m_buf.delete();
          m_coll = is_match;
          if (is_match) m_chan = 2'(int'(pw_wdata) - int'(CMD_BASE));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      checkOutput("cyc_valid", 64'(out_valid), 64'(m_vis));
      checkOutput("cyc_level", 64'(level), 64'(mq.size()));
      checkOutput("cyc_drop", 64'(drop_cnt), 64'(m_drop));
      checkOutput("cyc_irq", 64'(irq), 64'(m_irq));
      if (m_vis) begin
        checkOutput("cyc_data", out_data, mq[0].word);
        checkOutput("cyc_chan", 64'(out_chan), 64'(mq[0].chan));
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] d, input logic stb, input logic cmd, input logic endf);
    pw_wdata = d; pw_wstb = stb; pw_wcmd = cmd; pw_end = endf;
    @(negedge clk);
    pw_wstb = 1'b0; pw_wcmd = 1'b0; pw_end = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_data"}, out_data, 64'd0);
    checkOutput({tag, "_chan"}, 64'(out_chan), 64'd0);
    checkOutput({tag, "_level"}, 64'(level), 64'd0);
    checkOutput({tag, "_drop"}, 64'(drop_cnt), 64'd0);
    checkOutput({tag, "_irq"}, 64'(irq), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    checkReset("reset");
    rst = 1'b0;

    // Single word on channel 1, pw_end coincident with the last byte.
    applyStimulus(8'he3, 1, 1, 0);
    for (int i = 1; i <= 8; i++) applyStimulus(8'(i), 1, 0, i == 8);
    checkOutput("t1_level_N", 64'(level), 64'd0);
    @(negedge clk);
    checkOutput("t1_level_N1", 64'(level), 64'd1);
    checkOutput("t1_valid_N1", 64'(out_valid), 64'd0);
    @(negedge clk);
    checkOutput("t1_valid_N2", 64'(out_valid), 64'd1);
    checkOutput("t1_data", out_data, 64'h0102030405060708);
    checkOutput("t1_chan", 64'(out_chan), 64'd1);

    // Burst of 20 bytes on channel 0: two words, tail discarded.
    applyStimulus(8'he2, 1, 1, 0);
    for (int i = 0; i < 20; i++) applyStimulus(8'(8'h10 + i), 1, 0, 0);
    applyStimulus(8'h00, 0, 0, 1);
    checkOutput("t2_level", 64'(level), 64'd3);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("t2_w0", out_data, 64'h1011121314151617);
    checkOutput("t2_c0", 64'(out_chan), 64'd0);
    @(negedge clk);
    checkOutput("t2_w1", out_data, 64'h18191a1b1c1d1e1f);
    checkOutput("t2_level1", 64'(level), 64'd1);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("t2_empty", 64'(level), 64'd0);

    // Command outside the channel range is ignored.
    applyStimulus(8'he4, 1, 1, 0);
    for (int i = 0; i < 8; i++) applyStimulus(8'(8'h30 + i), 1, 0, 0);
    applyStimulus(8'h00, 0, 0, 1);
    repeat (3) @(negedge clk);
    checkOutput("t3_level", 64'(level), 64'd0);
    checkOutput("t3_valid", 64'(out_valid), 64'd0);

    // Overflow: six words into four entries.
    applyStimulus(8'he2, 1, 1, 0);
    for (int i = 0; i < 48; i++) applyStimulus(8'(8'h40 + i), 1, 0, 0);
    applyStimulus(8'h00, 0, 0, 1);
    repeat (3) @(negedge clk);
    checkOutput("t4_level_full", 64'(level), 64'd4);
    checkOutput("t4_drop2", 64'(drop_cnt), 64'd2);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checkOutput("t4_clr", 64'(drop_cnt), 64'd0);
    applyStimulus(8'he3, 1, 1, 0);
    for (int i = 0; i < 8; i++) applyStimulus(8'(8'ha0 + i), 1, 0, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("t4_popfull_level", 64'(level), 64'd4);
    checkOutput("t4_popfull_drop", 64'(drop_cnt), 64'd0);
    applyStimulus(8'he3, 1, 1, 0);
    for (int i = 0; i < 8; i++) applyStimulus(8'(8'hb0 + i), 1, 0, 0);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checkOutput("t4_clrwins", 64'(drop_cnt), 64'd0);
    for (int i = 0; i < 8; i++) applyStimulus(8'(8'hc0 + i), 1, 0, 0);
    repeat (2) @(negedge clk);
    checkOutput("t4_drop1", 64'(drop_cnt), 64'd1);
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    out_ready = 1'b0;
    checkOutput("t4_drained", 64'(level), 64'd0);
    applyStimulus(8'h00, 0, 0, 1);

    // Command switch mid-word discards the partial word.
    applyStimulus(8'he2, 1, 1, 0);
    applyStimulus(8'h55, 1, 0, 0);
    applyStimulus(8'h66, 1, 0, 0);
    applyStimulus(8'h77, 1, 0, 0);
    applyStimulus(8'he3, 1, 1, 0);
    for (int i = 1; i <= 8; i++) applyStimulus(8'(8'hc0 + i), 1, 0, 0);
    applyStimulus(8'h00, 0, 0, 1);
    repeat (2) @(negedge clk);
    checkOutput("t5_level", 64'(level), 64'd1);
    checkOutput("t5_data", out_data, 64'hc1c2c3c4c5c6c7c8);
    checkOutput("t5_chan", 64'(out_chan), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Watermark: three words drained back to back.
    applyStimulus(8'he2, 1, 1, 0);
    for (int i = 0; i < 24; i++) applyStimulus(8'(8'h80 + i), 1, 0, 0);
    applyStimulus(8'h00, 0, 0, 1);
    repeat (3) @(negedge clk);
    checkOutput("t6_level3", 64'(level), 64'd3);
    checkOutput("t6_irq_l3", 64'(irq), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("t6_irq_l2", 64'(irq), 64'd0);
    @(negedge clk);
    checkOutput("t6_level1", 64'(level), 64'd1);
    checkOutput("t6_irq_l1", 64'(irq), 64'd0);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("t6_level0", 64'(level), 64'd0);
    checkOutput("t6_irq_after", 64'(irq), 64'(IRQ_ON));

    // Reset in the middle of a burst with words queued and a nonzero drop count.
    applyStimulus(8'he3, 1, 1, 0);
    for (int i = 0; i < 19; i++) applyStimulus(8'(8'h20 + i), 1, 0, 0);
    checkOutput("t7_level_pre", 64'(level), 64'd2);
    rst = 1'b1;
    applyStimulus(8'h99, 1, 0, 0);
    rst = 1'b0;
    checkReset("t7_rst");
    for (int i = 0; i < 8; i++) applyStimulus(8'(8'h60 + i), 1, 0, 0);
    repeat (3) @(negedge clk);
    checkOutput("t7_idle_level", 64'(level), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
